// File: rtl/servo_slew_scheduler.sv
// servo_slew_scheduler
// Sequences the shared duty bus and the per-channel latch strobes of a
// 4-channel servo PWM controller. Each channel keeps a target duty that its
// own requester can write at any time. Once per frame, every channel's current
// duty moves toward its target by at most STEP. Each channel whose duty
// changed gets one latch strobe, and the channels are served one at a time.
//
// Ports:
//   clock      system clock
//   reset      synchronous, active-high reset
//   req        req[i] writes req_duty[8i+7:8i] into channel i's target
//   req_duty   packed target duties, one byte per channel
//   ack        ack[i] pulses one cycle after req[i] is accepted
//   duty       duty value presented to the PWM controller
//   latch      one-hot, single-cycle latch strobe per channel
//   busy       high while a sweep is in progress
//   frame_tick single-cycle pulse in the last cycle of each frame
module servo_slew_scheduler #(
    parameter int unsigned FRAME_CYCLES = 1_000_000,  // must be >= 16
    parameter int unsigned STEP         = 8,          // 0..255, 0 = jump to target
    parameter logic [7:0]  INIT_DUTY    = 8'h80
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [31:0] req_duty,
    output logic [3:0]  ack,
    output logic [7:0]  duty,
    output logic [3:0]  latch,
    output logic        busy,
    output logic        frame_tick
);

    localparam int unsigned     CNT_W   = $clog2(FRAME_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [8:0]      STEP9   = 9'(STEP);
    localparam logic [7:0]      STEP8   = 8'(STEP);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_STROBE
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        ch_q, ch_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0][7:0]   cur_q, cur_d;
    logic [3:0][7:0]   target_q, target_d;
    logic [7:0]        duty_q, duty_d;
    logic [3:0]        latch_q, latch_d;
    logic [3:0]        ack_q, ack_d;
    logic              busy_q, busy_d;
    logic              force_q, force_d;
    logic [7:0]        next_duty;

    // The difference is formed in 9 bits so the step never wraps past
    // 0x00 or 0xFF. Because the step is applied only when the remaining
    // distance is larger than STEP, the 8-bit add or subtract stays in range.
    function automatic logic [7:0] slew_step(input logic [7:0] cur, input logic [7:0] tgt);
        logic [8:0] diff;
        if (tgt >= cur) diff = {1'b0, tgt} - {1'b0, cur};
        else            diff = {1'b0, cur} - {1'b0, tgt};
        if (STEP == 0 || diff <= STEP9) return tgt;
        else if (tgt > cur)             return cur + STEP8;
        else                            return cur - STEP8;
    endfunction

    assign frame_tick = (cnt_q == CNT_MAX);
    assign next_duty  = slew_step(cur_q[ch_q], target_q[ch_q]);

    always_comb begin
        // NOTE: every signal gets a default first, so no branch leaves a
        // value unassigned and no latch is inferred.
        state_d  = state_q;
        ch_d     = ch_q;
        cur_d    = cur_q;
        duty_d   = duty_q;
        latch_d  = 4'b0000;
        force_d  = force_q;
        target_d = target_q;
        cnt_d    = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
        ack_d    = req;

        for (int i = 0; i < 4; i++) begin
            if (req[i]) target_d[i] = req_duty[8*i +: 8];
        end

        case (state_q)
            S_IDLE: begin
                if (frame_tick) begin
                    state_d = S_LOAD;
                    ch_d    = 2'd0;
                end
            end
            S_LOAD: begin
                if (next_duty != cur_q[ch_q] || force_q) begin
                    cur_d[ch_q] = next_duty;
                    duty_d      = next_duty;
                    latch_d     = 4'b0001 << ch_q;  // registered, so it is seen in STROBE
                    state_d     = S_STROBE;
                end else if (ch_q == 2'd3) begin
                    state_d = S_IDLE;
                end else begin
                    ch_d = ch_q + 2'd1;
                end
            end
            S_STROBE: begin
                if (ch_q == 2'd3) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_LOAD;
                    ch_d    = ch_q + 2'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // The forced re-latch after reset covers exactly one full sweep.
        if (state_q != S_IDLE && state_d == S_IDLE) force_d = 1'b0;
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            ch_q     <= 2'd0;
            cnt_q    <= '0;
            // NOTE: the per-channel duty registers are reset on purpose. With
            // only eight bytes of state, a known INIT_DUTY start is worth the
            // reset fan-out.
            cur_q    <= {4{INIT_DUTY}};
            target_q <= {4{INIT_DUTY}};
            duty_q   <= 8'h00;
            latch_q  <= 4'b0000;
            ack_q    <= 4'b0000;
            busy_q   <= 1'b0;
            force_q  <= 1'b1;
        end else begin
            // NOTE: all state is updated with non-blocking assignments, so
            // every register samples values from before this edge.
            state_q  <= state_d;
            ch_q     <= ch_d;
            cnt_q    <= cnt_d;
            cur_q    <= cur_d;
            target_q <= target_d;
            duty_q   <= duty_d;
            latch_q  <= latch_d;
            ack_q    <= ack_d;
            busy_q   <= busy_d;
            force_q  <= force_d;
        end
    end

    assign ack   = ack_q;
    assign duty  = duty_q;
    assign latch = latch_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_servo_slew_scheduler.sv
// Directed bench for servo_slew_scheduler. Two instances with a 100-cycle
// frame are used, one with STEP=16 (slewing) and one with STEP=0 (direct
// jump). The expected latch, duty and busy timeline of each sweep is built
// from the channel strobe mask, using the strobe timing rule: the first strobe
// is at tick+2, each earlier strobed channel adds 2 cycles, and each earlier
// skipped channel adds 1 cycle.
module tb_servo_slew_scheduler;

    localparam int FRAME = 100;

    logic        clock;
    logic        rst_a, rst_b;
    logic        use_s0;
    logic [3:0]  req_drv;
    logic [31:0] req_duty_drv;
    logic [3:0]  req_a, req_b;

    logic [3:0]  ack_a, latch_a, ack_b, latch_b;
    logic [7:0]  duty_a, duty_b;
    logic        busy_a, tick_a, busy_b, tick_b;

    logic [3:0]  obs_ack, obs_latch;
    logic [7:0]  obs_duty;
    logic        obs_busy, obs_tick;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int tick_cyc = 0;

    assign req_a = use_s0 ? 4'b0000 : req_drv;
    assign req_b = use_s0 ? req_drv : 4'b0000;

    servo_slew_scheduler #(.FRAME_CYCLES(FRAME), .STEP(16), .INIT_DUTY(8'h80)) u_s16 (
        .clock(clock), .reset(rst_a), .req(req_a), .req_duty(req_duty_drv),
        .ack(ack_a), .duty(duty_a), .latch(latch_a), .busy(busy_a), .frame_tick(tick_a)
    );

    servo_slew_scheduler #(.FRAME_CYCLES(FRAME), .STEP(0), .INIT_DUTY(8'h80)) u_s0 (
        .clock(clock), .reset(rst_b), .req(req_b), .req_duty(req_duty_drv),
        .ack(ack_b), .duty(duty_b), .latch(latch_b), .busy(busy_b), .frame_tick(tick_b)
    );

    always_comb begin
        if (use_s0) begin
            obs_ack = ack_b; obs_latch = latch_b; obs_duty = duty_b;
            obs_busy = busy_b; obs_tick = tick_b;
        end else begin
            obs_ack = ack_a; obs_latch = latch_a; obs_duty = duty_a;
            obs_busy = busy_a; obs_tick = tick_a;
        end
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] req_duty;
        logic [3:0]  mask;      // channels expected to strobe next frame
        logic [31:0] duties;    // strobed duty per channel
        int          busy_len;  // busy cycles after the tick
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_tick();
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!obs_tick && n < 3 * FRAME);
        if (!obs_tick) begin
            n_cmp++;
            n_fail++;
            $display("FAIL frame_tick_timeout: got none expected tick within %0d cycles", 3 * FRAME);
        end
        tick_cyc = cyc;
    endtask

    // Called at the sample point of the frame_tick cycle. It checks offsets
    // 0..11. It can also inject a request at offset inj_off (0 = none) and
    // check its ack one cycle later.
    task automatic check_sweep(input string name, input logic [3:0] mask, input logic [31:0] duties,
                               input int busy_len, input logic [7:0] prev_duty,
                               input int inj_off, input logic [3:0] inj_req, input logic [31:0] inj_data);
        logic [3:0] el [12];
        logic [7:0] ed [12];
        int so [4];
        int t;
        logic [7:0] d;
        t = 1;
        for (int ch = 0; ch < 4; ch++) begin
            if (mask[ch]) begin so[ch] = t + 1; t += 2; end
            else          begin so[ch] = -1;    t += 1; end
        end
        d = prev_duty;
        for (int off = 0; off < 12; off++) begin
            el[off] = 4'b0000;
            for (int ch = 0; ch < 4; ch++) begin
                if (so[ch] == off) begin
                    el[off] = 4'(1 << ch);
                    d = duties[8*ch +: 8];
                end
            end
            ed[off] = d;
        end
        check($sformatf("%s off0 latch/busy", name), {obs_latch, obs_busy}, 5'b0);
        for (int off = 1; off < 12; off++) begin
            @(negedge clock);
            check($sformatf("%s off%0d latch/duty/busy", name, off),
                  {obs_latch, obs_duty, obs_busy}, {el[off], ed[off], off <= busy_len});
            if (inj_off > 0 && off == inj_off + 1) begin
                check($sformatf("%s inj_ack", name), obs_ack, inj_req);
                req_drv = 4'b0000;
            end
            if (inj_off > 0 && off == inj_off) begin
                req_drv      = inj_req;
                req_duty_drv = inj_data;
            end
        end
    endtask

    vec_t       vecs [6];
    logic [7:0] s16_exp [8];
    logic [7:0] prev;
    int         t1;

    initial begin
        vecs[0] = '{4'h0, 32'h0000_0000, 4'hF, 32'h8080_8080, 8};  // forced re-latch after reset
        vecs[1] = '{4'h0, 32'h0000_0000, 4'h0, 32'h0000_0000, 4};  // nothing changed
        vecs[2] = '{4'h4, 32'h0000_0000, 4'h4, 32'h0000_0000, 5};  // ch2 -> 0x00
        vecs[3] = '{4'hF, 32'h4030_2010, 4'hF, 32'h4030_2010, 8};  // all four at once
        vecs[4] = '{4'hA, 32'hFF00_2000, 4'h8, 32'hFF00_0000, 5};  // ch1 unchanged, ch3 -> 0xFF
        vecs[5] = '{4'h1, 32'h0000_00FF, 4'h1, 32'h0000_00FF, 5};  // ch0 -> 0xFF
        s16_exp = '{8'h90, 8'hA0, 8'hB0, 8'hC0, 8'hD0, 8'hE0, 8'hF0, 8'hFF};

        use_s0 = 1'b0;
        req_drv = 4'b0000;
        req_duty_drv = 32'h0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (3) @(negedge clock);

        // Reset values
        check("rst ack", obs_ack, 4'b0000);
        check("rst duty", obs_duty, 8'h00);
        check("rst latch", obs_latch, 4'b0000);
        check("rst busy", obs_busy, 1'b0);
        check("rst frame_tick", obs_tick, 1'b0);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // First frame re-latches every channel; the next frame is quiet.
        wait_tick();
        t1 = tick_cyc;
        check_sweep("t1_first", 4'hF, 32'h8080_8080, 8, 8'h00, 0, 4'h0, 32'h0);
        wait_tick();
        check("frame_period", 32'(tick_cyc - t1), 32'(FRAME));
        check_sweep("t1_quiet", 4'h0, 32'h0, 4, 8'h80, 0, 4'h0, 32'h0);

        // STEP=16: ch0 slews from 0x80 to 0xFF over 8 frames.
        req_drv = 4'b0001;
        req_duty_drv = 32'h0000_00FF;
        @(negedge clock);
        check("t2 ack", obs_ack, 4'b0001);
        req_drv = 4'b0000;
        @(negedge clock);
        check("t2 ack_drop", obs_ack, 4'b0000);
        prev = 8'h80;
        for (int f = 0; f < 8; f++) begin
            wait_tick();
            check_sweep($sformatf("t2_f%0d", f), 4'h1, {24'h0, s16_exp[f]}, 5, prev, 0, 4'h0, 32'h0);
            prev = s16_exp[f];
        end
        wait_tick();
        check_sweep("t2_f8", 4'h0, 32'h0, 4, 8'hFF, 0, 4'h0, 32'h0);

        // STEP=0 instance, freshly reset; table-driven frames.
        use_s0 = 1'b1;
        rst_b = 1'b1;
        repeat (2) @(negedge clock);
        rst_b = 1'b0;
        prev = 8'h00;
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].req != 4'b0000) begin
                req_drv = vecs[i].req;
                req_duty_drv = vecs[i].req_duty;
                @(negedge clock);
                check($sformatf("vec%0d ack", i), obs_ack, vecs[i].req);
                req_drv = 4'b0000;
            end
            wait_tick();
            check_sweep($sformatf("vec%0d", i), vecs[i].mask, vecs[i].duties, vecs[i].busy_len,
                        prev, 0, 4'h0, 32'h0);
            for (int ch = 0; ch < 4; ch++)
                if (vecs[i].mask[ch]) prev = vecs[i].duties[8*ch +: 8];
        end

        // Mid-sweep writes: during LOAD(1) the value lands this sweep; during
        // LOAD(3) itself it lands in the next sweep.
        wait_tick();
        check_sweep("t5_during_load1", 4'h8, 32'h0500_0000, 5, 8'hFF, 2, 4'h8, 32'h0500_0000);
        wait_tick();
        check_sweep("t5_during_load3", 4'h0, 32'h0, 4, 8'h05, 4, 4'h8, 32'h0600_0000);
        wait_tick();
        check_sweep("t5_next_frame", 4'h8, 32'h0600_0000, 5, 8'h05, 0, 4'h0, 32'h0);

        // Reset during STROBE(1) of the first sweep after reset.
        rst_b = 1'b1;
        repeat (2) @(negedge clock);
        rst_b = 1'b0;
        wait_tick();
        repeat (2) @(negedge clock);
        check("t6 strobe0", obs_latch, 4'b0001);
        repeat (2) @(negedge clock);
        check("t6 strobe1", obs_latch, 4'b0010);
        rst_b = 1'b1;
        @(negedge clock);
        rst_b = 1'b0;
        check("t6 rst latch", obs_latch, 4'b0000);
        check("t6 rst duty", obs_duty, 8'h00);
        check("t6 rst busy", obs_busy, 1'b0);
        wait_tick();
        check_sweep("t6_relatch", 4'hF, 32'h8080_8080, 8, 8'h00, 0, 4'h0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
